// File: rtl/xlnxdemo_axil_master_if.sv
// AXI4-Lite bus bundle between the xlnxdemo initiator and its register slave.
// The master modport is the initiator's view; the slave modport mirrors it.
interface xlnxdemo_axil_master_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 7,
    parameter int C_M_AXI_DATA_WIDTH = 32
);
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/xlnxdemo_axil_master.sv
// AXI4-Lite initiator: one command in, one single-beat read or write on the bus,
// one response out. Only one transaction is ever in flight.
module xlnxdemo_axil_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 7,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            busy,
    xlnxdemo_axil_master_if.master          m_axi
);
    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, RSP} state_t;

    state_t                        state;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_aligned;
    logic                          aw_fin;
    logic                          w_fin;

    assign addr_aligned = cmd_addr & ~C_M_AXI_ADDR_WIDTH'(3);

    // A channel is finished once its valid has dropped or it handshakes this cycle.
    assign aw_fin = !m_axi.awvalid || m_axi.awready;
    assign w_fin  = !m_axi.wvalid  || m_axi.wready;

    // NOTE: cmd_ready is gated by the reset input so it is low in every reset cycle,
    // not just after the first reset edge.
    assign cmd_ready = (state == IDLE) && !M_AXI_ARESET;
    assign busy      = (state != IDLE);

    assign m_axi.awprot = 3'b000;
    assign m_axi.arprot = 3'b000;

    // NOTE: all state and outputs use non-blocking assignments so every branch
    // below sees the pre-edge values, independent of statement order.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state         <= IDLE;
            m_axi.awaddr  <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wdata   <= '0;
            m_axi.wstrb   <= '0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            m_axi.awaddr  <= addr_aligned;
                            m_axi.wdata   <= cmd_wdata;
                            m_axi.wstrb   <= cmd_wstrb;
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            state         <= WR;
                        end else begin
                            m_axi.araddr  <= addr_aligned;
                            m_axi.arvalid <= 1'b1;
                            state         <= RD_A;
                        end
                    end
                end
                WR: begin
                    if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
                    if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        m_axi.bready <= 1'b1;
                        state        <= WR_B;
                    end
                end
                WR_B: begin
                    if (m_axi.bvalid) begin
                        m_axi.bready <= 1'b0;
                        rsp_resp     <= m_axi.bresp;
                        rsp_rdata    <= '0;
                        rsp_write    <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RD_A: begin
                    if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state         <= RD_D;
                    end
                end
                RD_D: begin
                    if (m_axi.rvalid) begin
                        m_axi.rready <= 1'b0;
                        rsp_resp     <= m_axi.rresp;
                        rsp_rdata    <= m_axi.rdata;
                        rsp_write    <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xlnxdemo_axil_master.sv
// Bench for xlnxdemo_axil_master: register-slave model with programmable ready
// delays, word-level memory reference, directed cases then random traffic.
module tb_xlnxdemo_axil_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    xlnxdemo_axil_master_if #(.C_M_AXI_ADDR_WIDTH(7), .C_M_AXI_DATA_WIDTH(32)) bus ();

    xlnxdemo_axil_master #(.C_M_AXI_ADDR_WIDTH(7), .C_M_AXI_DATA_WIDTH(32)) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_write    (rsp_write),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .busy         (busy),
        .m_axi        (bus)
    );

    // Slave configuration, set from the stimulus block.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit          b_hold = 1'b0;
    bit          r_force = 1'b0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] r_force_data = 32'h0;

    // Slave state.
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0;
    logic        got_aw, got_w;
    logic [6:0]  slv_awaddr;
    logic [31:0] slv_wdata;
    logic [3:0]  slv_wstrb;
    logic [31:0] slv_mem [32];
    logic        aw_now, w_now;

    logic [31:0] ref_mem [32];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    assign bus.awready = bus.awvalid && (aw_wait >= aw_delay);
    assign bus.wready  = bus.wvalid  && (w_wait  >= w_delay);
    assign bus.arready = bus.arvalid && (ar_wait >= ar_delay);
    assign aw_now = got_aw || (bus.awvalid && bus.awready);
    assign w_now  = got_w  || (bus.wvalid && bus.wready);

    always @(posedge clk) begin
        if (rst) begin
            got_aw     <= 1'b0;
            got_w      <= 1'b0;
            bus.bvalid <= 1'b0;
            bus.bresp  <= 2'b00;
            bus.rvalid <= 1'b0;
            bus.rresp  <= 2'b00;
            bus.rdata  <= 32'h0;
            aw_wait    <= 0;
            w_wait     <= 0;
            ar_wait    <= 0;
            for (int i = 0; i < 32; i++) slv_mem[i] <= 32'h0;
        end else begin
            if (bus.awvalid && !bus.awready) aw_wait <= aw_wait + 1; else aw_wait <= 0;
            if (bus.wvalid && !bus.wready)   w_wait  <= w_wait + 1;  else w_wait  <= 0;
            if (bus.arvalid && !bus.arready) ar_wait <= ar_wait + 1; else ar_wait <= 0;
            if (bus.awvalid && bus.awready) begin
                got_aw     <= 1'b1;
                slv_awaddr <= bus.awaddr;
                aw_hs      <= aw_hs + 1;
            end
            if (bus.wvalid && bus.wready) begin
                got_w     <= 1'b1;
                slv_wdata <= bus.wdata;
                slv_wstrb <= bus.wstrb;
                w_hs      <= w_hs + 1;
            end
            if (aw_now && w_now && !bus.bvalid && !b_hold) begin
                bus.bvalid <= 1'b1;
                bus.bresp  <= b_resp_cfg;
                slv_mem[got_aw ? slv_awaddr[6:2] : bus.awaddr[6:2]] <=
                    merge(slv_mem[got_aw ? slv_awaddr[6:2] : bus.awaddr[6:2]],
                          got_w ? slv_wdata : bus.wdata, got_w ? slv_wstrb : bus.wstrb);
                got_aw <= 1'b0;
                got_w  <= 1'b0;
            end
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (bus.arvalid && bus.arready) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= r_force ? r_force_data : slv_mem[bus.araddr[6:2]];
                bus.rresp  <= r_resp_cfg;
                ar_hs      <= ar_hs + 1;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    // Protocol monitor: payload stability while stalled, and stray responses.
    int          viol = 0, stray = 0;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [6:0]  p_awaddr, p_araddr;
    logic [35:0] p_w;

    always @(posedge clk) begin
        if (rst) begin
            p_awv <= 1'b0;
            p_wv  <= 1'b0;
            p_arv <= 1'b0;
        end else begin
            if (p_awv && !p_awr && (!bus.awvalid || bus.awaddr !== p_awaddr)) viol <= viol + 1;
            if (p_wv && !p_wr && (!bus.wvalid || {bus.wdata, bus.wstrb} !== p_w)) viol <= viol + 1;
            if (p_arv && !p_arr && (!bus.arvalid || bus.araddr !== p_araddr)) viol <= viol + 1;
            if ((bus.bvalid && !bus.bready) || (bus.rvalid && !bus.rready)) stray <= stray + 1;
            p_awv    <= bus.awvalid;
            p_awr    <= bus.awready;
            p_awaddr <= bus.awaddr;
            p_wv     <= bus.wvalid;
            p_wr     <= bus.wready;
            p_w      <= {bus.wdata, bus.wstrb};
            p_arv    <= bus.arvalid;
            p_arr    <= bus.arready;
            p_araddr <= bus.araddr;
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ctl();
        return {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
                rsp_valid, busy, cmd_ready};
    endfunction

    task automatic clear_ref();
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    endtask

    // One full command/response exchange; expected cycle timeline derived from slave delays.
    task automatic run_txn(input string tag, input bit wr, input logic [6:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb, input int hold);
        int          wt;
        int          lat;
        int          aw0, w0, ar0;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic [7:0]  exp_c;
        wt = 0;
        while (!cmd_ready && wt < 20) begin
            step();
            wt++;
        end
        check({tag, " accept"}, 64'(cmd_ready), 64'd1);
        if (!cmd_ready) return;
        exp_rdata = wr ? 32'h0 : (r_force ? r_force_data : ref_mem[addr[6:2]]);
        exp_resp  = wr ? b_resp_cfg : r_resp_cfg;
        lat = wr ? 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) : 3 + ar_delay;
        if (wr) ref_mem[addr[6:2]] = merge(ref_mem[addr[6:2]], wdata, wstrb);
        aw0 = aw_hs;
        w0  = w_hs;
        ar0 = ar_hs;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        rsp_ready = (hold == 0);
        step();
        cmd_valid = 1'b0;
        if (wr) check({tag, " aw/w payload"}, {bus.awaddr, bus.wdata, bus.wstrb},
                      {addr[6:2], 2'b00, wdata, wstrb});
        else    check({tag, " araddr"}, 64'(bus.araddr), 64'({addr[6:2], 2'b00}));
        for (int c = 1; c <= lat; c++) begin
            exp_c = {wr && (c <= 1 + aw_delay), wr && (c <= 1 + w_delay), wr && (c == lat - 1),
                     !wr && (c <= 1 + ar_delay), !wr && (c == lat - 1), c == lat, 1'b1, 1'b0};
            check($sformatf("%s ctl c%0d", tag, c), 64'(ctl()), 64'(exp_c));
            if (c < lat) step();
        end
        check({tag, " rsp"}, {rsp_write, rsp_resp, rsp_rdata}, {wr, exp_resp, exp_rdata});
        for (int h = 1; h <= hold; h++) begin
            step();
            check($sformatf("%s hold h%0d", tag, h), {ctl(), rsp_write, rsp_resp, rsp_rdata},
                  {8'b0000_0110, wr, exp_resp, exp_rdata});
        end
        rsp_ready = 1'b1;
        step();
        check({tag, " done"}, 64'(ctl()), 64'(8'b0000_0001));
        check({tag, " handshakes"}, {8'(aw_hs - aw0), 8'(w_hs - w0), 8'(ar_hs - ar0)},
              wr ? {8'd1, 8'd1, 8'd0} : {8'd0, 8'd0, 8'd1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        wr;
        logic [6:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b1;
        clear_ref();
        repeat (3) step();
        check("reset ctl", 64'(ctl()), 64'd0);
        check("reset aw/w", {bus.awaddr, bus.wdata, bus.wstrb}, 64'd0);
        check("reset ar/rsp", {bus.araddr, rsp_write, rsp_resp, rsp_rdata, bus.awprot, bus.arprot},
              64'd0);
        rst = 1'b0;
        #1;
        check("ready after reset", 64'(cmd_ready), 64'd1);

        run_txn("wr zero-wait", 1'b1, 7'h04, 32'h1234_5678, 4'hF, 0);
        aw_delay = 3;
        run_txn("wr aw late", 1'b1, 7'h04, 32'h1234_5678, 4'hF, 0);
        aw_delay = 0;
        run_txn("rd 0x04", 1'b0, 7'h04, 32'h0, 4'h0, 0);
        run_txn("rd 0x07", 1'b0, 7'h07, 32'h0, 4'h0, 0);

        r_force = 1'b1;
        r_force_data = 32'hDEAD_BEEF;
        r_resp_cfg = 2'b10;
        run_txn("rd slverr", 1'b0, 7'h08, 32'h0, 4'h0, 0);
        r_force = 1'b0;
        r_resp_cfg = 2'b00;

        b_resp_cfg = 2'b11;
        run_txn("wr strb0 decerr", 1'b1, 7'h0C, 32'hFFFF_FFFF, 4'h0, 0);
        b_resp_cfg = 2'b00;
        run_txn("wr partial", 1'b1, 7'h0C, 32'hA1B2_C3D4, 4'b0101, 0);
        run_txn("rd partial", 1'b0, 7'h0C, 32'h0, 4'h0, 0);
        run_txn("rd held", 1'b0, 7'h04, 32'h0, 4'h0, 5);

        w_delay = 2;
        run_txn("wr w late", 1'b1, 7'h20, 32'h0BAD_F00D, 4'hF, 0);
        w_delay = 0;
        ar_delay = 2;
        run_txn("rd ar late", 1'b0, 7'h20, 32'h0, 4'h0, 0);
        ar_delay = 0;

        // Reset while waiting for the write response.
        b_hold    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 7'h10;
        cmd_wdata = 32'h5555_AAAA;
        cmd_wstrb = 4'hF;
        step();
        cmd_valid = 1'b0;
        step();
        check("rstmid in wr_b", 64'(ctl()), 64'(8'b0010_0010));
        rst = 1'b1;
        step();
        check("rstmid ctl", 64'(ctl()), 64'd0);
        check("rstmid aw/w", {bus.awaddr, bus.wdata, bus.wstrb}, 64'd0);
        check("rstmid ar/rsp", {bus.araddr, rsp_write, rsp_resp, rsp_rdata}, 64'd0);
        rst    = 1'b0;
        b_hold = 1'b0;
        clear_ref();
        #1;
        check("rstmid ready", 64'(cmd_ready), 64'd1);
        run_txn("post-reset rd", 1'b0, 7'h10, 32'h0, 4'h0, 0);
        run_txn("post-reset wr", 1'b1, 7'h10, 32'h7777_8888, 4'hF, 0);
        run_txn("post-reset rd2", 1'b0, 7'h10, 32'h0, 4'h0, 0);

        for (int n = 0; n < 40; n++) begin
            wr       = 1'($urandom_range(0, 1));
            a        = 7'($urandom_range(0, 127));
            d        = $urandom;
            s        = 4'($urandom_range(0, 15));
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3);
            run_txn($sformatf("rand%0d", n), wr, a, d, s, $urandom_range(0, 2));
        end

        check("payload stability", 64'(viol), 64'd0);
        check("stray responses", 64'(stray), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
